uart_rx: RTL
============

Name: uart_rx

Overview:
8N1 UART receiver, LSB first, one start bit, one stop bit, no parity. It samples the asynchronous serial line through a 2-flop synchroniser and rejects start-bit glitches. Each bit is sampled at its mid-point and delivered as a byte with a 1-cycle valid strobe. It sits beside the UART transmitter on the same clock and uses the same bit timing, so TX output looped back to RX input yields identical bytes.

Parameters:
CLOCKS_PER_BIT, 10, bit period minus one. One bit lasts CLOCKS_PER_BIT+1 clocks (counter runs 0..CLOCKS_PER_BIT). Legal range 3..65535.

Ports:
i_clock  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_rxSerial  input  1  asynchronous serial line; idles high
o_rxData  output  8  last correctly framed byte; held until the next good byte
o_rxValid  output  1  1-cycle pulse: o_rxData updated this cycle
o_rxBusy  output  1  high whenever state != IDLE
o_frameError  output  1  1-cycle pulse: stop bit sampled low

Behaviour:
- Reset (i_reset high at a clock edge; priority over everything, including mid-frame):
  - state=IDLE, counters=0, shift register=0.
  - o_rxData=0, o_rxValid=0, o_frameError=0, o_rxBusy=0.
  - Both synchroniser flops=1, so reset never fakes a start bit.
- Synchroniser: r_sync1<=i_rxSerial; r_sync2<=r_sync1. Only r_sync2 (the "line") is used downstream.
- Counters: 16-bit clock counter; 3-bit bit index. HALF = CLOCKS_PER_BIT/2 (integer division).
- IDLE:
  - Clock counter=0, bit index=0.
  - Line==0 -> STARTBIT.
- STARTBIT:
  - Counter increments each clock.
  - At counter==HALF, line==0 -> counter=0, go to DATABITS. The counter is now phase-aligned to bit mid-points.
  - At counter==HALF, line==1 -> glitch; return to IDLE. No output pulse.
- DATABITS:
  - Counter increments.
  - At counter==CLOCKS_PER_BIT: shift[bitIndex]<=line, counter=0.
  - bitIndex<7 -> bitIndex+1. bitIndex==7 -> STOPBIT.
- STOPBIT:
  - Counter increments.
  - At counter==CLOCKS_PER_BIT, line==1 -> o_rxData<=shift, o_rxValid=1 for the next cycle only, go to IDLE.
  - At counter==CLOCKS_PER_BIT, line==0 -> o_frameError=1 for the next cycle only, o_rxData unchanged, go to WAITIDLE.
- WAITIDLE: stay until line==1, then go to IDLE. This prevents a break condition from re-triggering reception.
- Latency: o_rxValid rises 1 clock after the stop-bit mid-sample. That is about (CLOCKS_PER_BIT+1)/2 clocks before the stop bit ends, so back-to-back frames with zero idle gap are received.
- o_rxValid and o_frameError are never high together. Neither is asserted in any other state.
- A line transition within a bit period is ignored except at the sample point. There is no majority vote.

Test Plan:
- CLOCKS_PER_BIT=10 (11-clock bits); send 0xA5 -> o_rxData=0xA5, o_rxValid high exactly 1 cycle, o_frameError never high, o_rxBusy low again immediately after.
- Line low for 3 clocks then high -> no o_rxValid, no o_frameError, o_rxBusy high for ≤6 clocks then low. A subsequent 0x3C is received correctly.
- Send 0xA5, then 0x3C with the stop bit forced low and held low 40 clocks -> o_frameError 1-cycle pulse, o_rxData stays 0xA5, o_rxBusy stays high until the line returns high. A following 0x81 is received as 0x81.
- Back-to-back 0x00 then 0xFF with no idle gap -> two o_rxValid pulses 110 clocks apart, data 0x00 then 0xFF.
- Assert i_reset for 1 clock during data bit 4 of 0x5A -> next cycle all outputs 0 and o_rxBusy=0, no pulse for the aborted byte. A fresh 0x5A sent once the line is idle is received as 0x5A.
- Loopback: connect the team UART transmitter (same CLOCKS_PER_BIT) to i_rxSerial; send 0x00..0xFF sequentially -> 256 o_rxValid pulses with matching data, zero frame errors.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop synchroniser, start-glitch rejection and mid-bit sampling
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 10
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rxSerial,
  output logic [7:0] o_rxData,
  output logic       o_rxValid,
  output logic       o_rxBusy,
  output logic       o_frameError
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] STARTBIT = 3'd1;
  localparam logic [2:0] DATABITS = 3'd2;
  localparam logic [2:0] STOPBIT  = 3'd3;
  localparam logic [2:0] WAITIDLE = 3'd4;

  localparam logic [15:0] BIT_LAST = 16'(CLOCKS_PER_BIT);
  localparam logic [15:0] HALF     = 16'(CLOCKS_PER_BIT / 2);

  logic       rSync1;
  logic       rSync2;
  logic [2:0] state;
  logic [15:0] clockCount;
  logic [2:0] bitIndex;
  logic [7:0] shiftReg;

  // Reset both flops high so a reset can never look like a start bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rSync1 <= 1'b1;
      rSync2 <= 1'b1;
    end else begin
      rSync1 <= i_rxSerial;
      rSync2 <= rSync1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      clockCount   <= 16'd0;
      bitIndex     <= 3'd0;
      shiftReg     <= 8'd0;
      o_rxData     <= 8'd0;
      o_rxValid    <= 1'b0;
      o_frameError <= 1'b0;
    end else begin
      o_rxValid    <= 1'b0;
      o_frameError <= 1'b0;
      case (state)
        IDLE: begin
          clockCount <= 16'd0;
          bitIndex   <= 3'd0;
          if (!rSync2) begin
            state <= STARTBIT;
          end
        end

        // Re-check the line half a bit in; restarting the counter here aligns later samples to mid-bit.
        STARTBIT: begin
          if (clockCount == HALF) begin
            clockCount <= 16'd0;
            state      <= rSync2 ? IDLE : DATABITS;
          end else begin
            clockCount <= clockCount + 16'd1;
          end
        end

        DATABITS: begin
          if (clockCount == BIT_LAST) begin
            clockCount         <= 16'd0;
            shiftReg[bitIndex] <= rSync2;
            if (bitIndex == 3'd7) begin
              bitIndex <= 3'd0;
              state    <= STOPBIT;
            end else begin
              bitIndex <= bitIndex + 3'd1;
            end
          end else begin
            clockCount <= clockCount + 16'd1;
          end
        end

        // Completing at the stop-bit mid-point leaves half a bit of slack for a back-to-back start bit.
        STOPBIT: begin
          if (clockCount == BIT_LAST) begin
            clockCount <= 16'd0;
            if (rSync2) begin
              o_rxData  <= shiftReg;
              o_rxValid <= 1'b1;
              state     <= IDLE;
            end else begin
              o_frameError <= 1'b1;
              state        <= WAITIDLE;
            end
          end else begin
            clockCount <= clockCount + 16'd1;
          end
        end

        // A held-low line (break) must return high before another start bit is accepted.
        WAITIDLE: begin
          clockCount <= 16'd0;
          if (rSync2) begin
            state <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          clockCount <= 16'd0;
          bitIndex   <= 3'd0;
        end
      endcase
    end
  end

  assign o_rxBusy = (state != IDLE);

endmodule
